dp_wr_ctrl: RTL and testbench
=============================

// Module: dp_wr_ctrl
// PURPOSE
//  FX3 slave-FIFO write engine for one data port. Started by a one-cycle strobe
//  from the data port arbiter (one bit of its strt vector) once SLADDR/SLCSn are set.
//  Drains a first-word-fall-through fabric FIFO onto the FX3 DQ bus in bursts and
//  commits short packets with PKTENDn. Returns a one-cycle done pulse to the arbiter.
//  SLWRn_o/PKTENDn_o feed the arbiter's per-port SLWRn/PKTENDn mux inputs.
// PARAMETERS
//  DATA_W      32    FX3 DQ / FIFO data width
//  BURST_LEN   256   max words written per grant (>=1)
//  PKT_WORDS   256   words per FX3 DMA buffer (auto-commit size)
//  ADDR_SETUP  2     wait cycles after strt_i before first write (>=1)
//  WAIT_TMO    1024  cycles waited for data/space before giving up the grant (>=1)
// PORTS
//  clk_i       in   1       clock
//  rstn_i      in   1       asynchronous active-low reset
//  strt_i      in   1       grant strobe from arbiter, 1 cycle
//  done_o      out  1       grant finished, 1-cycle pulse
//  flagFull_ni in   1       FX3 full flag, 0 = current buffer full
//  flagWm_ni   in   1       FX3 watermark flag, 0 = free space below watermark
//  fifo_dout_i in   DATA_W  FWFT FIFO head word
//  fifo_empty_i in  1       FIFO empty
//  fifo_rd_o   out  1       FIFO pop (combinational from state + inputs)
//  dq_o        out  DATA_W  FX3 DQ write data (registered)
//  SLWRn_o     out  1       slave write strobe, active low (registered)
//  PKTENDn_o   out  1       packet end, active low (registered)
// BEHAVIOUR
//  Reset (async, rstn_i=0): state IDLE, done_o=0, SLWRn_o=1, PKTENDn_o=1, dq_o=0,
//   fifo_rd_o=0, all counters 0. Takes effect immediately, also mid-burst.
//  wrEn = (state==WR) & ~fifo_empty_i & flagWm_ni & (burstCnt<BURST_LEN);
//   fifo_rd_o=wrEn; next cycle: SLWRn_o=~wrEn_q, dq_o=word popped (data and strobe aligned).
//  pktCnt: words in current FX3 buffer; +1 per write, wraps PKT_WORDS-1 -> 0.
//   It persists across grants and is cleared only by PKTEND or reset.
//  burstCnt: words this grant, cleared on strt_i. tmoCnt: cleared on entry to CHK.
//  States:
//   IDLE  : strt_i -> SETUP (setCnt=0). strt_i ignored in all other states.
//   SETUP : ADDR_SETUP cycles, then -> CHK.
//   CHK   : flagFull_ni=1 & flagWm_ni=1 & ~fifo_empty_i -> WR;
//           else tmoCnt++; at tmoCnt==WAIT_TMO-1: pktCnt!=0 -> PKTEND, else -> FIN.
//   WR    : writes while wrEn. Exit priority (evaluated same cycle):
//           1) burstCnt reaches BURST_LEN (incl. this write) -> FIN
//           2) flagWm_ni=0 -> FIN (no PKTEND, buffer left open)
//           3) fifo_empty_i=1 -> CHK
//   PKTEND: PKTENDn_o=0 for exactly 1 cycle with SLWRn_o=1; pktCnt<=0; -> FIN.
//   FIN   : done_o=1 for 1 cycle; -> IDLE.
//  Latency: strt_i at cycle 0, FIFO/flags ready -> first SLWRn_o low at cycle
//   ADDR_SETUP+3; full burst = BURST_LEN consecutive low cycles.
//  done_o follows the last SLWRn_o/PKTENDn_o low cycle by 1-2 cycles (never overlaps).
//  Watermark is sized so 1 in-flight write after flagWm_ni=0 still fits.
//  Undefined state encodings recover to IDLE.
// TESTING
//  1 Assert rstn_i=0 mid-run -> SLWRn_o=1, PKTENDn_o=1, done_o=0, dq_o=0 immediately.
//  2 FIFO 300 words, flags high, strt_i -> 256 consecutive writes, data in order;
//    then done_o 1 cycle; 44 words remain; pktCnt=0.
//  3 strt_i again, WAIT_TMO=16 -> 44 writes; then FIFO empty for 16 cycles.
//    Then PKTENDn_o low 1 cycle, then done_o. Repeat with exactly 256 words -> no PKTEND.
//  4 flagWm_ni->0 after 100 writes -> at most 1 further write, done_o, no PKTEND.
//  5 strt_i, FIFO empty, pktCnt=0 -> done_o after WAIT_TMO+ADDR_SETUP+2 cycles.
//    No SLWRn_o/PKTENDn_o activity.
//  6 FIFO goes empty for 5 cycles mid-burst, then refills -> WR->CHK->WR; no word lost or duplicated.

Source files
------------

// File: rtl/dp_wr_ctrl.sv
// FX3 slave-FIFO write engine for one data port: drains a first-word-fall-through
// FIFO onto DQ in bursts per arbiter grant and commits short packets with PKTENDn.
module dp_wr_ctrl #(
   parameter int DATA_W     = 32,
   parameter int BURST_LEN  = 256,
   parameter int PKT_WORDS  = 256,
   parameter int ADDR_SETUP = 2,
   parameter int WAIT_TMO   = 1024
) (
   input  logic              clk_i,
   input  logic              rstn_i,
   input  logic              strt_i,
   output logic              done_o,
   input  logic              flagFull_ni,
   input  logic              flagWm_ni,
   input  logic [DATA_W-1:0] fifo_dout_i,
   input  logic              fifo_empty_i,
   output logic              fifo_rd_o,
   output logic [DATA_W-1:0] dq_o,
   output logic              SLWRn_o,
   output logic              PKTENDn_o
);

   localparam int BW = $clog2(BURST_LEN + 1);
   localparam int PW = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
   localparam int SW = (ADDR_SETUP > 1) ? $clog2(ADDR_SETUP) : 1;
   localparam int TW = (WAIT_TMO > 1) ? $clog2(WAIT_TMO) : 1;

   localparam logic [BW-1:0] BURST_MAX = BW'(BURST_LEN);
   localparam logic [PW-1:0] PKT_LAST  = PW'(PKT_WORDS - 1);
   localparam logic [SW-1:0] SET_LAST  = SW'(ADDR_SETUP - 1);
   localparam logic [TW-1:0] TMO_LAST  = TW'(WAIT_TMO - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETUP  = 3'd1,
      CHK    = 3'd2,
      WR     = 3'd3,
      PKTEND = 3'd4,
      FIN    = 3'd5
   } state_t;

   state_t          state;
   state_t          next_state;
   logic            wr_en;
   logic            burst_done;
   logic [BW-1:0]   burst_cnt;
   logic [BW-1:0]   burst_inc;
   logic [PW-1:0]   pkt_cnt;
   logic [SW-1:0]   set_cnt;
   logic [TW-1:0]   tmo_cnt;

   assign burst_inc = burst_cnt + BW'(1);
   assign fifo_rd_o = wr_en;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      wr_en      = 1'b0;
      burst_done = 1'b0;
      case (state)
         IDLE: begin
            if (strt_i) next_state = SETUP;
         end
         SETUP: begin
            if (set_cnt == SET_LAST) next_state = CHK;
         end
         CHK: begin
            if (flagFull_ni && flagWm_ni && !fifo_empty_i) begin
               next_state = WR;
            end else if (tmo_cnt == TMO_LAST) begin
               next_state = (pkt_cnt != '0) ? PKTEND : FIN;
            end
         end
         WR: begin
            wr_en      = !fifo_empty_i && flagWm_ni && (burst_cnt < BURST_MAX);
            // The write happening this cycle counts toward the burst limit
            burst_done = wr_en ? (burst_inc == BURST_MAX) : (burst_cnt == BURST_MAX);
            if (burst_done) begin
               next_state = FIN;
            end else if (!flagWm_ni) begin
               next_state = FIN;
            end else if (fifo_empty_i) begin
               next_state = CHK;
            end
         end
         PKTEND: begin
            next_state = FIN;
         end
         FIN: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         set_cnt   <= '0;
         tmo_cnt   <= '0;
         burst_cnt <= '0;
         pkt_cnt   <= '0;
      end else begin
         set_cnt <= (state == SETUP) ? set_cnt + SW'(1) : '0;
         // Zero everywhere except while lingering in CHK, so every entry starts fresh
         tmo_cnt <= (state == CHK && next_state == CHK) ? tmo_cnt + TW'(1) : '0;
         if (state == IDLE && strt_i) begin
            burst_cnt <= '0;
         end else if (wr_en) begin
            burst_cnt <= burst_inc;
         end
         // Buffer fill survives across grants; only a commit or reset empties it
         if (state == PKTEND) begin
            pkt_cnt <= '0;
         end else if (wr_en) begin
            pkt_cnt <= (pkt_cnt == PKT_LAST) ? '0 : pkt_cnt + PW'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         done_o    <= 1'b0;
         SLWRn_o   <= 1'b1;
         PKTENDn_o <= 1'b1;
         dq_o      <= '0;
      end else begin
         done_o    <= (state == FIN);
         SLWRn_o   <= !wr_en;
         PKTENDn_o <= (state != PKTEND);
         if (wr_en) begin
            dq_o <= fifo_dout_i;
         end
      end
   end

endmodule

// File: tb/tb_dp_wr_ctrl.sv
// Directed bench for dp_wr_ctrl: a FWFT FIFO model feeds the DUT, a per-cycle
// monitor checks data order and strobe rules, and each grant is checked against hand values.
module tb_dp_wr_ctrl;

   localparam int DATA_W     = 32;
   localparam int BURST_LEN  = 256;
   localparam int PKT_WORDS  = 256;
   localparam int ADDR_SETUP = 2;
   localparam int WAIT_TMO   = 16;

   logic              clk = 1'b0;
   logic              rstn_i = 1'b0;
   logic              strt_i = 1'b0;
   logic              done_o;
   logic              flagFull_ni = 1'b1;
   logic              flagWm_ni = 1'b1;
   logic [DATA_W-1:0] fifo_dout_i = '0;
   logic              fifo_empty_i = 1'b1;
   logic              fifo_rd_o;
   logic [DATA_W-1:0] dq_o;
   logic              SLWRn_o;
   logic              PKTENDn_o;

   always #5 clk = ~clk;

   dp_wr_ctrl #(
      .DATA_W(DATA_W), .BURST_LEN(BURST_LEN), .PKT_WORDS(PKT_WORDS),
      .ADDR_SETUP(ADDR_SETUP), .WAIT_TMO(WAIT_TMO)
   ) dut (
      .clk_i(clk), .rstn_i(rstn_i), .strt_i(strt_i), .done_o(done_o),
      .flagFull_ni(flagFull_ni), .flagWm_ni(flagWm_ni),
      .fifo_dout_i(fifo_dout_i), .fifo_empty_i(fifo_empty_i), .fifo_rd_o(fifo_rd_o),
      .dq_o(dq_o), .SLWRn_o(SLWRn_o), .PKTENDn_o(PKTENDn_o)
   );

   logic [DATA_W-1:0] fifo_q[$];
   logic [DATA_W-1:0] all_words[$];
   int  errors = 0;
   int  checks = 0;
   int  cyc = 0;
   int  word_id = 0;
   logic rd_seen = 1'b0;
   bit  chk_en = 1'b1;
   int  wr_total = 0;
   int  pkt_model = 0;
   logic done_prev = 1'b0;
   int  g_strt = 0, g_writes = 0, g_pktends = 0, g_first = -1, g_last = -1, g_done = -1;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic push_words(input int n);
      logic [DATA_W-1:0] w;
      for (int i = 0; i < n; i++) begin
         w = (DATA_W'(word_id) << 8) | (DATA_W'($urandom) & DATA_W'(8'hFF));
         word_id++;
         fifo_q.push_back(w);
         all_words.push_back(w);
      end
   endtask

   // FWFT FIFO model: pop what the DUT read at the last edge, then present the new head
   always begin
      @(negedge clk);
      if (rd_seen && fifo_q.size() > 0) void'(fifo_q.pop_front());
      #1;
      fifo_empty_i = (fifo_q.size() == 0);
      fifo_dout_i  = (fifo_q.size() > 0) ? fifo_q[0] : '0;
      #1;
      rd_seen = fifo_rd_o;
   end

   // Per-cycle monitor: in-order data, burst limit, legal commits, isolated done pulses
   always begin
      @(negedge clk);
      #3;
      if (strt_i) begin
         g_strt = cyc; g_writes = 0; g_pktends = 0; g_first = -1; g_last = -1; g_done = -1;
      end
      if (!rstn_i) begin
         pkt_model = 0;
      end else begin
         if (SLWRn_o === 1'b0) begin
            g_writes++;
            if (g_first < 0) g_first = cyc - g_strt;
            g_last = cyc - g_strt;
            if (chk_en) begin
               if (wr_total < all_words.size()) check("dq_order", dq_o, all_words[wr_total]);
               else check("dq_extra_write", wr_total, all_words.size());
               wr_total++;
               check("burst_limit", (g_writes <= BURST_LEN), 1);
            end
            pkt_model = (pkt_model + 1) % PKT_WORDS;
         end
         if (PKTENDn_o === 1'b0) begin
            g_pktends++;
            g_last = cyc - g_strt;
            check("pktend_slwr_high", SLWRn_o, 1);
            check("pktend_has_words", (pkt_model != 0), 1);
            pkt_model = 0;
         end
         if (done_o === 1'b1) begin
            g_done = cyc - g_strt;
            check("done_alone", {SLWRn_o, PKTENDn_o}, 2'b11);
            check("done_one_cycle", done_prev, 0);
         end
      end
      done_prev = done_o;
   end

   task automatic run_grant(input string name, input int exp_wr, input int exp_pe,
                            input int exp_first, input int exp_done, input int exp_gap,
                            input int wm_drop, input int full_rel, input int refill_n);
      int empty_cyc;
      bit refilled;
      bit seen;
      empty_cyc = 0; refilled = 1'b0; seen = 1'b0;
      @(negedge clk);
      strt_i = 1'b1;
      for (int k = 1; k <= 3000 && !seen; k++) begin
         @(negedge clk);
         strt_i = 1'b0;
         if (wm_drop > 0 && g_writes >= wm_drop) flagWm_ni = 1'b0;
         if (full_rel > 0 && k == full_rel) flagFull_ni = 1'b1;
         if (refill_n > 0 && !refilled && g_writes > 0 && fifo_q.size() == 0) begin
            empty_cyc++;
            if (empty_cyc == 5) begin
               push_words(refill_n);
               refilled = 1'b1;
            end
         end
         seen = (g_done >= 0);
      end
      check({name, "_done_seen"}, seen, 1);
      check({name, "_writes"}, g_writes, exp_wr);
      check({name, "_pktends"}, g_pktends, exp_pe);
      if (exp_first >= 0) check({name, "_first_wr_lat"}, g_first, exp_first);
      if (exp_done >= 0) check({name, "_done_lat"}, g_done, exp_done);
      if (exp_gap >= 0) check({name, "_done_gap"}, g_done - g_last, exp_gap);
      $display("grant %s: writes=%0d pktend=%0d first=%0d last=%0d done=%0d",
               name, g_writes, g_pktends, g_first, g_last, g_done);
      flagWm_ni = 1'b1;
      flagFull_ni = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      #1;
      check("rst_slwr", SLWRn_o, 1);
      check("rst_pktend", PKTENDn_o, 1);
      check("rst_done", done_o, 0);
      check("rst_dq", dq_o, 0);
      check("rst_fifo_rd", fifo_rd_o, 0);
      @(negedge clk);
      rstn_i = 1'b1;
      @(negedge clk);

      push_words(300);
      run_grant("burst300", 256, 0, ADDR_SETUP + 3, ADDR_SETUP + 3 + BURST_LEN, 1, 0, 0, 0);
      check("left_after_burst", fifo_q.size(), 44);

      run_grant("tail44", 44, 1, 5, 67, 1, 0, 0, 0);
      check("left_after_tail", fifo_q.size(), 0);

      push_words(256);
      run_grant("exact256", 256, 0, 5, 261, 1, 0, 0, 0);

      run_grant("empty_pkt0", 0, 0, -1, WAIT_TMO + ADDR_SETUP + 2, -1, 0, 0, 0);

      push_words(150);
      run_grant("wm_drop", 101, 0, 5, 107, 2, 100, 0, 0);

      run_grant("refill", 109, 1, 5, -1, 1, 0, 0, 60);
      check("refill_fifo_drained", fifo_q.size(), 0);
      check("refill_no_loss", wr_total, all_words.size());

      push_words(10);
      flagFull_ni = 1'b0;
      run_grant("full_hold", 10, 1, 10, 38, 1, 0, 8, 0);

      // Mid-burst asynchronous reset
      push_words(50);
      @(negedge clk);
      strt_i = 1'b1;
      @(negedge clk);
      strt_i = 1'b0;
      for (int k = 0; k < 400 && g_writes < 20; k++) @(negedge clk);
      check("midrst_writing", (g_writes >= 20 && SLWRn_o === 1'b0), 1);
      chk_en = 1'b0;
      rstn_i = 1'b0;
      #1;
      check("midrst_slwr", SLWRn_o, 1);
      check("midrst_pktend", PKTENDn_o, 1);
      check("midrst_done", done_o, 0);
      check("midrst_dq", dq_o, 0);
      check("midrst_fifo_rd", fifo_rd_o, 0);
      $display("mid-burst reset applied after %0d writes", g_writes);
      repeat (3) @(negedge clk);
      fifo_q.delete();
      @(negedge clk);
      rstn_i = 1'b1;
      @(negedge clk);
      run_grant("post_reset_empty", 0, 0, -1, WAIT_TMO + ADDR_SETUP + 2, -1, 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
